// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO read port onto a valid/ready stream through a 2-entry skid buffer.
// Optional `FIFO_RD_COUNT_EN adds the rd_count delivered-word counter.
module fifo_stream_reader #(
  parameter int unsigned data_width = 32
`ifdef FIFO_RD_COUNT_EN
  ,
  parameter int unsigned cnt_width = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [data_width-1:0] fifo_data_out,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [data_width-1:0] m_data,
  output logic                  busy
`ifdef FIFO_RD_COUNT_EN
  ,
  output logic [cnt_width-1:0]  rd_count
`endif
);

  typedef enum logic [1:0] {StIdle, StActive, StStopping} state_e;

  state_e                state_q;
  logic [1:0]            occ_q;
  logic                  inflight_q;
  logic [data_width-1:0] head_q;
  logic [data_width-1:0] tail_q;
  logic                  pop;
  logic [2:0]            slots_used;

  assign pop        = m_valid & m_ready;
  // A pop in this cycle frees a slot, so m_ready feeds the read strobe directly.
  assign slots_used = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd_en = (state_q == StActive) & ~fifo_empty & (slots_used < 3'd2);
  assign fifo_cs    = fifo_rd_en;
  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = head_q;
  assign busy       = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      inflight_q <= fifo_rd_en;
      occ_q      <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
      if (pop) begin
        head_q <= tail_q;
      end
      // Captured word lands at the first free slot after this edge's pop.
      if (inflight_q) begin
        if (occ_q == 2'd0 || (occ_q == 2'd1 && pop)) begin
          head_q <= fifo_data_out;
        end else begin
          tail_q <= fifo_data_out;
        end
      end
      unique case (state_q)
        StIdle: begin
          if (en) state_q <= StActive;
        end
        StActive: begin
          if (!en) state_q <= StStopping;
        end
        StStopping: begin
          if (en) begin
            state_q <= StActive;
          end else if (!inflight_q && occ_q == 2'd0) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef FIFO_RD_COUNT_EN
  logic [cnt_width-1:0] rd_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_q <= '0;
    end else if (pop) begin
      rd_count_q <= rd_count_q + 1'b1;
    end
  end

  assign rd_count = rd_count_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ({1'b0, occ_q} + {2'b00, inflight_q} <= 3'd2)
      else $error("fifo_stream_reader: output buffer overflow");
    end
  end
`endif

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain engine for the team's synchronous FIFO. It pops words through the FIFO's `cs`/`rd_en`/`data_out`/`empty` read port and presents them on a valid/ready stream with one word per cycle sustained throughput. It absorbs the FIFO's one-cycle registered read latency in a 2-entry output buffer. It sits between the FIFO and any downstream consumer that may stall.

## Interface
Parameters:
- `data_width`, 32, width of FIFO words and stream data
- `cnt_width`, 16, width of `rd_count` (only with `FIFO_RD_COUNT_EN`)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  level; 1 = drain FIFO, 0 = stop issuing reads
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_data_out`  in  `data_width`  FIFO registered read data
- `fifo_cs`  out  1  FIFO chip select; equal to `fifo_rd_en`
- `fifo_rd_en`  out  1  FIFO read strobe (combinational)
- `m_valid`  out  1  stream data valid
- `m_ready`  in  1  downstream accept
- `m_data`  out  `data_width`  stream data, head of output buffer
- `busy`  out  1  state != IDLE
- `rd_count`  out  `cnt_width`  words delivered (only with `FIFO_RD_COUNT_EN`)

## Operation
- FIFO read contract: a read is sampled at edge k when `fifo_cs & fifo_rd_en & !fifo_empty`. `fifo_data_out` is valid throughout cycle k+1.
- `inflight` flag: set at edge k for each read issued; the word is captured into the buffer at edge k+1.
- Output buffer: 2-entry FIFO of registers, `occ` ∈ {0,1,2}. `m_data` = head, `m_valid` = (occ != 0). A pop occurs on `m_valid & m_ready`.
- Read issue (combinational): `fifo_rd_en = (state==ACTIVE) & !fifo_empty & (occ + inflight - pop < 2)`. A same-cycle pop frees a slot, so the `m_ready`→`fifo_rd_en` path is combinational by design.
- Simultaneous capture and pop at the same edge: `occ` is unchanged, order is preserved, and the head advances.
- The buffer never overflows. Reaching `occ + inflight > 2` is a design error; assertion under simulation.
- States:
  - IDLE: no reads issued. Goes to ACTIVE when `en`=1.
  - ACTIVE: reads issued per the rule above. Goes to STOPPING when `en`=0.
  - STOPPING: no new reads. Goes to IDLE once `inflight`=0 and `occ`=0. Goes back to ACTIVE if `en` returns to 1.
- Clearing `en` never drops a word: in-flight and buffered words are still delivered.

## Timing
- Reset (async assert, synchronous-release usage): state=IDLE, `occ`=0, `inflight`=0, `m_valid`=0, `m_data`=0, `busy`=0, `rd_count`=0. `fifo_rd_en`/`fifo_cs` are 0 because state is IDLE.
- Reset mid-operation: in-flight and buffered words are discarded. The FIFO-side pointer advance from an already-sampled read is not undone.
- Latency: `en` rising at edge e → earliest `fifo_rd_en` in cycle e+1 (state ACTIVE after edge e). Read edge k → `m_valid`=1 after edge k+1.
- Throughput: 1 word/cycle while `m_ready`=1 and the FIFO is non-empty.
- `m_ready`=0 stall: at most 2 further reads complete, then `fifo_rd_en` holds 0 until a pop.
- `m_valid`/`m_data` stay stable while `m_valid & !m_ready`.
- FIFO goes empty mid-burst: `fifo_rd_en` drops the same cycle. Words already in flight are still delivered.

## Configuration
- `FIFO_RD_COUNT_EN` defined:
  - `rd_count` port exists and increments by 1 on every pop.
  - Wraps modulo 2^`cnt_width`.
  - Reset to 0.
- `FIFO_RD_COUNT_EN` undefined: `rd_count` port and counter are absent; all other behaviour is identical.

## Test plan
- Preload FIFO with 1, 20, 120; `en`=1; `m_ready`=1 → `m_data` sequence 1, 20, 120 on 3 consecutive `m_valid` cycles; then `busy` stays 1 and `fifo_rd_en`=0 while `fifo_empty`=1.
- Preload 8 words 2^0..2^7; `m_ready`=1 → 8 back-to-back valid cycles in order; `fifo_rd_en` high for 8 consecutive cycles; `rd_count`=8.
- Preload 8 words; `m_ready`=0 for 10 cycles → exactly 2 reads issued, `m_data`=1 held stable. Release → remaining 7 words delivered in order, none lost or duplicated.
- Deassert `en` in the cycle of a read of value 5 → 5 is still delivered, no further reads, state goes STOPPING→IDLE, `busy`=0.
- Assert `rst_n`=0 with `occ`=2 → `m_valid`=0, `busy`=0, `fifo_rd_en`=0 immediately, without waiting for a clock edge.
- Random `m_ready` (50%) over 1000 words with FIFO refilled randomly → output stream matches the write order exactly; the overflow assertion never fires.
